// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative MIPS divider: operand width and FSM state encodings.
package div_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Returns {remainder, quotient} for the HI/LO write and stalls the front end while iterating.
module div_unit
  import div_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opa,
  input  logic [DATA_W-1:0]     opb,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stall_req
);

  div_state_e state, state_nxt;
  logic [4:0] cnt;

  // Latched operands. acc holds {partial remainder, dividend/quotient}.
  logic [DATA_W-1:0]   opa_raw;
  logic [DATA_W-1:0]   divisor;
  logic [2*DATA_W-1:0] acc;
  logic                q_neg;
  logic                r_neg;

  logic [2*DATA_W:0]   acc_shift;
  logic [DATA_W:0]     trial;
  logic [2*DATA_W-1:0] acc_step;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Two's-complement negate when en is set.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic en);
    return en ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Magnitude of a signed operand; unsigned operands pass through. |0x80000000| stays 0x80000000.
  function automatic logic [DATA_W-1:0] abs_if(input logic [DATA_W-1:0] v, input logic sgn);
    return neg_if(v, sgn & v[DATA_W-1]);
  endfunction

  // One restoring step: shift, trial-subtract, keep the difference when it does not borrow.
  always_comb begin
    acc_shift = {acc, 1'b0};
    trial     = acc_shift[2*DATA_W:DATA_W] - {1'b0, divisor};
    if (trial[DATA_W])
      acc_step = acc_shift[2*DATA_W-1:0];
    else
      acc_step = {trial[DATA_W-1:0], acc_shift[DATA_W-1:1], 1'b1};
    quot_fix  = neg_if(acc[DATA_W-1:0], q_neg);
    rem_fix   = neg_if(acc[2*DATA_W-1:DATA_W], r_neg);
  end

  // Next-state logic; annul overrides everything, start is only honoured in DIV_FREE.
  always_comb begin
    state_nxt = state;
    if (annul) begin
      state_nxt = DIV_FREE;
    end else begin
      case (state)
        DIV_FREE:   if (start) state_nxt = (opb == '0) ? DIV_BYZERO : DIV_ON;
        DIV_BYZERO: state_nxt = DIV_FREE;
        DIV_ON:     if (cnt == 5'd31) state_nxt = DIV_END;
        DIV_END:    state_nxt = DIV_FREE;
        default:    state_nxt = DIV_FREE;
      endcase
    end
  end

  // Stall the front end from the request cycle through the last iteration; a zero divisor needs none.
  assign stall_req = (state == DIV_ON) ||
                     ((state == DIV_FREE) && start && !annul && (opb != '0));

  // Control state, iteration counter and the completed-result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= DIV_FREE;
      cnt    <= '0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      state <= state_nxt;
      ready <= 1'b0;
      if (!annul) begin
        case (state)
          DIV_FREE:   cnt <= '0;
          DIV_ON:     cnt <= cnt + 5'd1;
          DIV_END: begin
            result <= {rem_fix, quot_fix};
            ready  <= 1'b1;
          end
          DIV_BYZERO: begin
            result <= {opa_raw, {DATA_W{1'b1}}};
            ready  <= 1'b1;
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

  // Operand capture at request time, then one iteration per cycle while in DIV_ON.
  always_ff @(posedge clk) begin
    if (state == DIV_FREE && start) begin
      opa_raw <= opa;
      divisor <= abs_if(opb, signed_div);
      acc     <= {{DATA_W{1'b0}}, abs_if(opa, signed_div)};
      q_neg   <= signed_div & (opa[DATA_W-1] ^ opb[DATA_W-1]);
      r_neg   <= signed_div & opa[DATA_W-1];
    end else if (state == DIV_ON) begin
      acc     <= acc_step;
    end
  end

endmodule
